// File: rtl/sprite_fetch.sv
// sprite_fetch
//   Walks a w x h rectangle of a 256x256 sprite sheet in raster order,
//   issues one texel address per cycle to a 1-cycle-latency sprite ROM and
//   streams the returned palette indices out through a 2-entry FIFO with a
//   valid/ready handshake.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   req_valid/req_ready  sprite request handshake
//   req_sx, req_sy       top-left texel of the sprite in the sheet
//   req_w, req_h         sprite size in texels (0..32; 0 means no pixels)
//   rom_addr, rom_data   sprite ROM address out / index back one cycle later
//   pix_valid/pix_ready  pixel handshake
//   pix_idx, pix_opaque  palette index and "not transparent" flag
//   pix_col, pix_row     texel offset inside the sprite
//   pix_last             final pixel of the sprite
//   busy                 high whenever not IDLE
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high
// FETCH | issuing texel addresses as FIFO credit allows
// DRAIN | all addresses issued; waiting for the last pixel to be popped

module sprite_fetch #(
    parameter int                SHEET_BITS = 8,
    parameter int                IDX_W      = 5,
    parameter logic [IDX_W-1:0]  TRANSP_IDX = 5'h00
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SHEET_BITS-1:0]   req_sx,
    input  logic [SHEET_BITS-1:0]   req_sy,
    input  logic [5:0]              req_w,
    input  logic [5:0]              req_h,
    output logic [2*SHEET_BITS-1:0] rom_addr,
    input  logic [IDX_W-1:0]        rom_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [IDX_W-1:0]        pix_idx,
    output logic                    pix_opaque,
    output logic [4:0]              pix_col,
    output logic [4:0]              pix_row,
    output logic                    pix_last,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state;
    logic [SHEET_BITS-1:0]  sx_q, sy_q;
    logic [5:0]             w_q, h_q;
    logic [4:0]             col, row;

    // One address in flight: tags travel alongside the ROM access.
    logic                   infl_v;
    logic [4:0]             infl_col, infl_row;
    logic                   infl_last;

    // 2-entry output FIFO
    logic [IDX_W-1:0]       f_idx  [2];
    logic [4:0]             f_col  [2];
    logic [4:0]             f_row  [2];
    logic                   f_last [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count;

    logic                   pop, push, issue, col_end, row_end, issue_last;
    logic [SHEET_BITS-1:0]  addr_x, addr_y;

    // Counters only move on issue, so the address naturally holds while
    // stalled and keeps the last texel through DRAIN and IDLE.
    assign addr_x   = sx_q + SHEET_BITS'(col);
    assign addr_y   = sy_q + SHEET_BITS'(row);
    assign rom_addr = {addr_y, addr_x};

    assign pix_valid  = (count != 2'd0);
    assign pop        = pix_valid & pix_ready;
    assign push       = infl_v;

    assign col_end    = ({1'b0, col} == w_q - 6'd1);
    assign row_end    = ({1'b0, row} == h_q - 6'd1);
    assign issue_last = col_end & row_end;

    // Credit check: entries held + entry in flight - entry leaving now < 2.
    assign issue = (state == FETCH) &&
                   (({1'b0, count} + {2'b00, infl_v}) < (3'd2 + {2'b00, pop}));

    assign pix_idx    = f_idx[rd_ptr];
    assign pix_col    = f_col[rd_ptr];
    assign pix_row    = f_row[rd_ptr];
    assign pix_last   = pix_valid & f_last[rd_ptr];
    assign pix_opaque = (pix_idx != TRANSP_IDX);

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            sx_q      <= '0;
            sy_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col       <= '0;
            row       <= '0;
            infl_v    <= 1'b0;
            infl_col  <= '0;
            infl_row  <= '0;
            infl_last <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_idx[i]  <= '0;
                f_col[i]  <= '0;
                f_row[i]  <= '0;
                f_last[i] <= 1'b0;
            end
        end else begin
            infl_v <= issue;
            if (issue) begin
                infl_col  <= col;
                infl_row  <= row;
                infl_last <= issue_last;
            end

            if (push) begin
                f_idx[wr_ptr]  <= rom_data;
                f_col[wr_ptr]  <= infl_col;
                f_row[wr_ptr]  <= infl_row;
                f_last[wr_ptr] <= infl_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    // Zero-size requests are consumed without touching the
                    // sheet origin, so rom_addr stays put.
                    if (req_valid && req_w != 6'd0 && req_h != 6'd0) begin
                        sx_q  <= req_sx;
                        sy_q  <= req_sy;
                        w_q   <= req_w;
                        h_q   <= req_h;
                        col   <= '0;
                        row   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (issue_last) begin
                            state <= DRAIN;
                        end else if (col_end) begin
                            col <= '0;
                            row <= row + 5'd1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && f_last[rd_ptr])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch
//   Self-checking bench for sprite_fetch: a table of sprite requests with
//   expected pixel counts and first addresses, a ROM model with a few
//   transparent texels, a pixel scoreboard, and hand-written sequences for
//   address ordering and mid-sprite reset.

module tb_sprite_fetch;

    logic        Clk;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_sx, req_sy;
    logic [5:0]  req_w, req_h;
    logic [15:0] rom_addr;
    logic [4:0]  rom_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [4:0]  pix_idx;
    logic        pix_opaque;
    logic [4:0]  pix_col, pix_row;
    logic        pix_last;
    logic        busy;

    sprite_fetch #(.SHEET_BITS(8), .IDX_W(5), .TRANSP_IDX(5'h00)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sx     (req_sx),
        .req_sy     (req_sy),
        .req_w      (req_w),
        .req_h      (req_h),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_idx    (pix_idx),
        .pix_opaque (pix_opaque),
        .pix_col    (pix_col),
        .pix_row    (pix_row),
        .pix_last   (pix_last),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM model: non-transparent texels give an index in 1..31.
    bit transp [0:65535];

    function automatic logic [4:0] rom_model(input logic [15:0] a);
        if (transp[a])
            return 5'h00;
        return 5'(((int'(a[7:0]) + int'(a[15:8])) % 31) + 1);
    endfunction

    always @(posedge Clk) rom_data <= rom_model(rom_addr);

    // pix_ready: 0 = always high, 1 = random 50%, 2 = always low
    int rdy_mode = 0;
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard entry: {idx, col, row, last, opaque}
    logic [16:0] exp_q[$];
    int          pop_count = 0;
    bit          mon_en = 0;
    bit          prev_stall = 0;
    bit          last_prev = 0;
    logic [16:0] prev_pix;

    always @(negedge Clk) begin
        logic [16:0] cur;
        logic [16:0] e;
        cur = {pix_idx, pix_col, pix_row, pix_last, pix_opaque};
        if (mon_en) begin
            if (Reset) begin
                prev_stall = 0;
                last_prev  = 0;
            end else begin
                if (last_prev) begin
                    chk("idle_after_last_ready", req_ready, 1);
                    chk("idle_after_last_busy", busy, 0);
                end
                if (prev_stall) begin
                    chk("stall_valid_hold", pix_valid, 1);
                    chk("stall_pix_hold", cur, prev_pix);
                end
                last_prev = 0;
                if (pix_valid && pix_ready) begin
                    chk("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("pixel", cur, e);
                    end
                    pop_count++;
                    last_prev = pix_last;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_pix   = cur;
            end
        end
    end

    typedef struct {
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic [5:0]  w;
        logic [5:0]  h;
        int          rdy;
        int          npix;
        logic [15:0] first;
        int          lit;
    } vec_t;

    vec_t        tbl[8];
    logic [15:0] lit_addr[2][8];

    task automatic wait_done(input int npix);
        int k = 0;
        while (k < 8000 && !(pop_count == npix && exp_q.size() == 0 && req_ready === 1'b1)) begin
            @(negedge Clk);
            k++;
        end
        chk("drain_in_budget", k < 8000, 1);
        chk("pix_count", pop_count, npix);
    endtask

    task automatic run_sprite(input vec_t t);
        logic [15:0] a;
        logic [15:0] ea;
        logic [4:0]  idx;
        rdy_mode  = t.rdy;
        pop_count = 0;
        for (int r = 0; r < int'(t.h); r++)
            for (int c = 0; c < int'(t.w); c++) begin
                a   = {8'(int'(t.sy) + r), 8'(int'(t.sx) + c)};
                idx = rom_model(a);
                exp_q.push_back({idx, 5'(c), 5'(r),
                                 1'((r == int'(t.h) - 1) && (c == int'(t.w) - 1)),
                                 1'(idx != 5'h00)});
            end
        @(posedge Clk);
        #1;
        req_sx = t.sx; req_sy = t.sy; req_w = t.w; req_h = t.h;
        req_valid = 1'b1;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        if (t.npix == 0) begin
            @(negedge Clk);
            chk("zero_ready", req_ready, 1);
            chk("zero_busy", busy, 0);
            repeat (3) begin
                chk("zero_no_pix", pix_valid, 0);
                @(negedge Clk);
            end
        end else begin
            @(negedge Clk);
            chk("first_addr", rom_addr, t.first);
            if (t.rdy == 0) begin
                for (int k = 0; k < t.npix; k++) begin
                    if (k > 0) @(negedge Clk);
                    if (t.lit != 0)
                        ea = lit_addr[t.lit - 1][k];
                    else
                        ea = {8'(int'(t.sy) + k / int'(t.w)), 8'(int'(t.sx) + k % int'(t.w))};
                    chk("addr_seq", rom_addr, ea);
                end
            end
        end
        wait_done(t.npix);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'd16,  8'd32,  6'd4,  6'd2,  0, 8,    16'h2010, 1};
        tbl[1] = '{8'd254, 8'd255, 6'd4,  6'd2,  0, 8,    16'hFFFE, 2};
        tbl[2] = '{8'd0,   8'd0,   6'd32, 6'd32, 1, 1024, 16'h0000, 0};
        tbl[3] = '{8'd100, 8'd7,   6'd1,  6'd1,  0, 1,    16'h0764, 0};
        tbl[4] = '{8'd10,  8'd20,  6'd0,  6'd5,  0, 0,    16'h0000, 0};
        tbl[5] = '{8'd5,   8'd5,   6'd7,  6'd0,  0, 0,    16'h0000, 0};
        tbl[6] = '{8'd200, 8'd250, 6'd9,  6'd3,  1, 27,   16'hFAC8, 0};
        tbl[7] = '{8'd30,  8'd40,  6'd32, 6'd1,  0, 32,   16'h281E, 0};

        lit_addr[0] = '{16'h2010, 16'h2011, 16'h2012, 16'h2013,
                        16'h2110, 16'h2111, 16'h2112, 16'h2113};
        lit_addr[1] = '{16'hFFFE, 16'hFFFF, 16'hFF00, 16'hFF01,
                        16'h00FE, 16'h00FF, 16'h0000, 16'h0001};

        transp[16'h2011] = 1;
        transp[16'h2112] = 1;
        transp[16'h0000] = 1;
        transp[16'h0510] = 1;
        transp[16'h1F1F] = 1;
        transp[16'hFBCA] = 1;
        transp[16'h2825] = 1;

        Reset = 1'b1; req_valid = 1'b0;
        req_sx = '0; req_sy = '0; req_w = '0; req_h = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rom_addr", rom_addr, 16'h0000);
        chk("rst_pix_last", pix_last, 0);
        mon_en = 1;

        for (int i = 0; i < 8; i++)
            run_sprite(tbl[i]);

        // Mid-sprite reset with the FIFO full and the consumer stalled.
        rdy_mode  = 2;
        pop_count = 0;
        @(posedge Clk);
        #1;
        req_sx = 8'd3; req_sy = 8'd4; req_w = 6'd32; req_h = 6'd32;
        req_valid = 1'b1;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(negedge Clk);
        chk("pre_rst_valid", pix_valid, 1);
        chk("pre_rst_busy", busy, 1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        exp_q.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_rom_addr", rom_addr, 16'h0000);
        run_sprite(tbl[0]);
        run_sprite(tbl[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter SHEET_BITS, default 8, per-axis sprite-sheet coordinate width (sheet = 256x256).
REQ-002 SHALL have parameter IDX_W, default 5, palette-index width returned by the sprite ROM.
REQ-003 SHALL have parameter TRANSP_IDX, default 5'h00, palette index treated as transparent.
REQ-004 SHALL have port Clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  sprite request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_sx, req_sy  input  8 each  top-left texel of the sprite in the sheet.
REQ-009 SHALL have port req_w, req_h  input  6 each  sprite width and height in texels, 0..32.
REQ-010 SHALL have port rom_addr  output  16  texel address to the sprite ROM.
REQ-011 SHALL have port rom_data  input  IDX_W  ROM output, valid exactly 1 cycle after rom_addr is presented.
REQ-012 SHALL have port pix_valid  output  1  pixel output valid.
REQ-013 SHALL have port pix_ready  input  1  downstream accepts the pixel.
REQ-014 SHALL have port pix_idx  output  IDX_W  palette index of the pixel.
REQ-015 SHALL have port pix_opaque  output  1  high when pix_idx != TRANSP_IDX.
REQ-016 SHALL have port pix_col, pix_row  output  5 each  texel offset within the sprite.
REQ-017 SHALL have port pix_last  output  1  final pixel of the sprite.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on req_valid && req_ready, latching sx, sy, w, h and zeroing the column/row counters.
REQ-021 SHALL, if the accepted w or h is 0, emit no pixels and remain in IDLE (no FETCH entry).
REQ-022 SHALL drive rom_addr = {(sy+row) mod 256, (sx+col) mod 256}; coordinates wrap independently per axis.
REQ-023 SHALL issue addresses in raster order: col 0..w-1 within each row, rows 0..h-1.
REQ-024 SHALL hold rom_addr stable in any cycle in which no address is issued.
REQ-025 SHALL track each issued address for its 1-cycle ROM latency and, in the following cycle, capture rom_data with its col, row and last tag into a 2-entry output FIFO.
REQ-026 SHALL issue an address in a cycle only if FIFO occupancy + in-flight count - (1 if pop this cycle) < 2, so the FIFO never overflows.
REQ-027 SHALL sustain one pixel per cycle while pix_ready is held high.
REQ-028 SHALL present the FIFO head on pix_*; pix_valid = FIFO non-empty; pop on pix_valid && pix_ready.
REQ-029 SHALL keep pix_* stable while pix_valid && !pix_ready.
REQ-030 SHALL move FETCH -> DRAIN in the cycle after issuing the address for (w-1, h-1).
REQ-031 SHALL move DRAIN -> IDLE in the cycle after the pix_last pixel is popped; a new request is accepted no earlier than that IDLE cycle.
REQ-032 SHALL assert pix_last only with the pixel at (w-1, h-1).
REQ-033 SHALL compute pix_opaque combinationally from the FIFO head index.

Reset
REQ-034 SHALL on Reset force state IDLE and set req_ready = 1, pix_valid = 0, pix_last = 0, busy = 0, rom_addr = 0, and the counters, FIFO and in-flight tracking to empty.
REQ-035 SHALL let Reset override every other input in the same cycle, including mid-FETCH/DRAIN, discarding in-flight data; pix_valid = 0 in the first cycle after Reset.

Verification
REQ-036 SHALL check: request sx=16,sy=32,w=4,h=2, pix_ready=1 -> rom_addr 0x2010..0x2013,0x2110..0x2113 on consecutive cycles; 8 pixels back-to-back; pix_last on (3,1); IDLE one cycle after.
REQ-037 SHALL check: sx=254,sy=255,w=4,h=2 -> addresses 0xFFFE,0xFFFF,0xFF00,0xFF01,0x00FE,0x00FF,0x0000,0x0001.
REQ-038 SHALL check: pix_ready toggled randomly (50%) on a 32x32 sprite -> 1024 pixels, no loss or duplication, raster order, pix_* stable while stalled.
REQ-039 SHALL check: ROM model returning TRANSP_IDX at chosen texels -> pix_opaque = 0 exactly at those pixels, 1 elsewhere.
REQ-040 SHALL check: w=0 or h=0 request -> no pix_valid, req_ready back high next cycle.
REQ-041 SHALL check: Reset asserted mid-sprite with 2 pixels buffered -> next cycle pix_valid=0, busy=0, req_ready=1; following request completes correctly.
